// File: rtl/point_collect.sv
// point_collect: gathers one frame of number_points 3-D points over a
// valid/ready handshake. It tracks the per-axis bounding box and counts
// back-to-back repeated points. When the frame is complete it serves
// one-cycle-latency reads from the point buffer.
module point_collect #(
    parameter int N             = 3,
    parameter int number_points = 14,
    localparam int CW = $clog2(number_points + 1),
    localparam int AW = (number_points > 1) ? $clog2(number_points) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pt_valid,
    input  logic [N-1:0]  X1,
    input  logic [N-1:0]  Y1,
    input  logic [N-1:0]  Z1,
    output logic          pt_ready,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count,
    output logic [CW-1:0] repeat_cnt,
    output logic [N-1:0]  xmin,
    output logic [N-1:0]  xmax,
    output logic [N-1:0]  ymin,
    output logic [N-1:0]  ymax,
    output logic [N-1:0]  zmin,
    output logic [N-1:0]  zmax,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [N-1:0]  rd_x,
    output logic [N-1:0]  rd_y,
    output logic [N-1:0]  rd_z
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_e;

    localparam logic [CW-1:0] LAST_IDX = CW'(number_points - 1);

    state_e state_q, state_d;

    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         repeat_q, repeat_d;
    logic [2:0][N-1:0]     min_q, min_d;
    logic [2:0][N-1:0]     max_q, max_d;
    logic [2:0][N-1:0]     prev_q, prev_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [2:0][N-1:0]     rd_data_q, rd_data_d;
    logic [2:0][N-1:0]     mem_q [number_points];

    logic [2:0][N-1:0]     pt;
    logic                  accept;
    logic                  clear_frame;

    // Index 0 is X, 1 is Y and 2 is Z throughout the datapath.
    assign pt          = {Z1, Y1, X1};
    assign accept      = pt_valid && (state_q == S_COLLECT);
    assign clear_frame = start && (state_q != S_COLLECT);

    // State register; reset sends the block back to IDLE on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start opens a frame, and the last accept closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: if (accept && (count_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:    if (start) state_d = S_COLLECT;
            default:   state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs are pure decodes of the state.
    always_comb begin
        pt_ready = (state_q == S_COLLECT);
        busy     = (state_q == S_COLLECT);
        done     = (state_q == S_DONE);
    end

    // Frame statistics: a start clears them, and each accepted point updates them.
    always_comb begin
        count_d  = count_q;
        repeat_d = repeat_q;
        min_d    = min_q;
        max_d    = max_q;
        prev_d   = prev_q;
        if (clear_frame) begin
            count_d  = '0;
            repeat_d = '0;
            min_d    = '0;
            max_d    = '0;
        end else if (accept) begin
            count_d = count_q + CW'(1);
            prev_d  = pt;
            if ((count_q != '0) && (pt == prev_q)) begin
                repeat_d = repeat_q + CW'(1);
            end
            for (int a = 0; a < 3; a++) begin
                if (count_q == '0) begin
                    min_d[a] = pt[a];
                    max_d[a] = pt[a];
                end else begin
                    if (pt[a] < min_q[a]) min_d[a] = pt[a];
                    if (pt[a] > max_q[a]) max_d[a] = pt[a];
                end
            end
        end
    end

    // Reads are served only in DONE. Out-of-range addresses still answer, with zeros.
    always_comb begin
        rd_valid_d = rd_en && (state_q == S_DONE);
        rd_data_d  = rd_data_q;
        if (rd_valid_d) begin
            if (32'(rd_addr) < number_points) begin
                rd_data_d = mem_q[rd_addr];
            end else begin
                rd_data_d = '0;
            end
        end
    end

    // Statistics and read-port registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            repeat_q   <= '0;
            min_q      <= '0;
            max_q      <= '0;
            prev_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            count_q    <= count_d;
            repeat_q   <= repeat_d;
            min_q      <= min_d;
            max_q      <= max_d;
            prev_q     <= prev_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Point buffer: no reset, and written only by an accept while reset is released.
    always_ff @(posedge clk) begin
        if (reset && accept) begin
            mem_q[count_q] <= pt;
        end
    end

    assign count      = count_q;
    assign repeat_cnt = repeat_q;
    assign xmin       = min_q[0];
    assign xmax       = max_q[0];
    assign ymin       = min_q[1];
    assign ymax       = max_q[1];
    assign zmin       = min_q[2];
    assign zmax       = max_q[2];
    assign rd_valid   = rd_valid_q;
    assign rd_x       = rd_data_q[0];
    assign rd_y       = rd_data_q[1];
    assign rd_z       = rd_data_q[2];

endmodule

// File: tb/tb_point_collect.sv
// tb_point_collect: directed scenario tests for point_collect, using
// expected values worked out by hand.
module tb_point_collect;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pt_valid;
    logic [2:0] X1, Y1, Z1;
    logic       pt_ready, busy, done;
    logic [3:0] count, repeat_cnt;
    logic [2:0] xmin, xmax, ymin, ymax, zmin, zmax;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic [2:0] rd_x, rd_y, rd_z;

    int passCount  = 0;
    int checkCount = 0;

    point_collect #(.N(3), .number_points(14)) dut (
        .clk(clk), .reset(reset), .start(start), .pt_valid(pt_valid),
        .X1(X1), .Y1(Y1), .Z1(Z1),
        .pt_ready(pt_ready), .busy(busy), .done(done),
        .count(count), .repeat_cnt(repeat_cnt),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax), .zmin(zmin), .zmax(zmax),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_x(rd_x), .rd_y(rd_y), .rd_z(rd_z)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a point with the given valid flag.
    task automatic applyStimulus(input logic v, input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
        pt_valid = v;
        X1 = x;
        Y1 = y;
        Z1 = z;
    endtask

    // Issue a single-cycle read request and step past the sampling edge.
    task automatic issueRead(input logic [3:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] allOut;
        reset = 1'b0;
        tick();
        tick();
        allOut = {pt_ready, busy, done, count, repeat_cnt, xmin, xmax, ymin, ymax, zmin, zmax, rd_valid, rd_x, rd_y, rd_z};
        checkCount++;
        if (allOut !== 36'd0) $display("[TB] FAIL reset_state: got %h expected 0", allOut);
        else passCount++;
        reset = 1'b1;
        applyStimulus(1'b1, 3'd5, 3'd5, 3'd5);
        for (int c = 0; c < 5; c++) begin
            tick();
            allOut = {pt_ready, busy, done, count, repeat_cnt, xmin, xmax, ymin, ymax, zmin, zmax, rd_valid, rd_x, rd_y, rd_z};
            checkCount++;
            if (allOut !== 36'd0) $display("[TB] FAIL idle_no_start cycle %0d: got %h expected 0", c, allOut);
            else passCount++;
        end
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
    endtask

    task automatic test_full_frame();
        logic [3:0] i4;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkCount++;
        if ({busy, pt_ready, done, count} !== {1'b1, 1'b1, 1'b0, 4'd0})
            $display("[TB] FAIL start_collect: got b%0d r%0d d%0d c%0d expected b1 r1 d0 c0", busy, pt_ready, done, count);
        else passCount++;
        for (int i = 0; i < 14; i++) begin
            i4 = 4'(i);
            applyStimulus(1'b1, i4[2:0], 3'd1, 3'd7 - i4[2:0]);
            tick();
            checkCount++;
            if ({count, done} !== {4'(i + 1), (i == 13)})
                $display("[TB] FAIL frame_accept %0d: got count %0d done %0d expected count %0d done %0d", i, count, done, i + 1, (i == 13));
            else passCount++;
        end
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
        checkCount++;
        if ({pt_ready, busy, repeat_cnt} !== {1'b0, 1'b0, 4'd0})
            $display("[TB] FAIL frame_end_flags: got r%0d b%0d rep%0d expected r0 b0 rep0", pt_ready, busy, repeat_cnt);
        else passCount++;
        checkCount++;
        if ({xmin, xmax, ymin, ymax, zmin, zmax} !== {3'd0, 3'd7, 3'd1, 3'd1, 3'd0, 3'd7})
            $display("[TB] FAIL frame_bbox: got %0d %0d %0d %0d %0d %0d expected 0 7 1 1 0 7", xmin, xmax, ymin, ymax, zmin, zmax);
        else passCount++;
    endtask

    task automatic test_readout();
        logic [3:0] addrs [4] = '{4'd0, 4'd5, 4'd13, 4'd15};
        logic [8:0] expd  [4] = '{{3'd0, 3'd1, 3'd7}, {3'd5, 3'd1, 3'd2}, {3'd5, 3'd1, 3'd2}, 9'd0};
        for (int k = 0; k < 4; k++) begin
            issueRead(addrs[k]);
            checkCount++;
            if ({rd_valid, rd_x, rd_y, rd_z} !== {1'b1, expd[k]})
                $display("[TB] FAIL read addr %0d: got v%0d (%0d,%0d,%0d) expected v1 data %h", addrs[k], rd_valid, rd_x, rd_y, rd_z, expd[k]);
            else passCount++;
        end
        tick();
        checkCount++;
        if (rd_valid !== 1'b0) $display("[TB] FAIL read_valid_drop: got %0d expected 0", rd_valid);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        issueRead(4'd2);
        start = 1'b0;
        checkCount++;
        if ({rd_valid, rd_x, rd_y, rd_z} !== {1'b1, 3'd2, 3'd1, 3'd5})
            $display("[TB] FAIL restart_read: got v%0d (%0d,%0d,%0d) expected v1 (2,1,5)", rd_valid, rd_x, rd_y, rd_z);
        else passCount++;
        checkCount++;
        if ({busy, done, count, repeat_cnt, xmin, xmax} !== {1'b1, 1'b0, 4'd0, 4'd0, 3'd0, 3'd0})
            $display("[TB] FAIL restart_clear: got b%0d d%0d c%0d rep%0d x%0d..%0d expected b1 d0 c0 rep0 x0..0", busy, done, count, repeat_cnt, xmin, xmax);
        else passCount++;
        start = 1'b1;
        applyStimulus(1'b1, 3'd3, 3'd3, 3'd3);
        tick();
        start = 1'b0;
        checkCount++;
        if ({busy, count, xmin, xmax} !== {1'b1, 4'd1, 3'd3, 3'd3})
            $display("[TB] FAIL start_ignored_in_collect: got b%0d c%0d x%0d..%0d expected b1 c1 x3..3", busy, count, xmin, xmax);
        else passCount++;
    endtask

    task automatic test_mid_reset();
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 3'(i), 3'(i), 3'(i));
            tick();
        end
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
        checkCount++;
        if ({count, xmin, xmax} !== {4'd6, 3'd1, 3'd5})
            $display("[TB] FAIL pre_reset_count: got c%0d x%0d..%0d expected c6 x1..5", count, xmin, xmax);
        else passCount++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkCount++;
        if ({busy, pt_ready, done, count, repeat_cnt, xmin, xmax, ymin, ymax, zmin, zmax} !== 29'd0)
            $display("[TB] FAIL mid_reset_state: got b%0d r%0d c%0d x%0d..%0d y%0d..%0d z%0d..%0d expected all 0", busy, pt_ready, count, xmin, xmax, ymin, ymax, zmin, zmax);
        else passCount++;
        issueRead(4'd0);
        checkCount++;
        if (rd_valid !== 1'b0) $display("[TB] FAIL idle_read: got rd_valid %0d expected 0", rd_valid);
        else passCount++;
    endtask

    task automatic test_repeats_stalls();
        logic [8:0] pts [14];
        logic [3:0] j4;
        logic [8:0] expd [4] = '{{3'd6, 3'd1, 3'd1}, {3'd6, 3'd1, 3'd1}, {3'd0, 3'd2, 3'd0}, {3'd2, 3'd3, 3'd0}};
        logic [3:0] addrs [4] = '{4'd0, 4'd2, 4'd3, 4'd13};
        for (int k = 0; k < 3; k++) pts[k] = {3'd6, 3'd1, 3'd1};
        for (int j = 0; j < 11; j++) begin
            j4 = 4'(j);
            pts[j + 3] = {j4[2:0], (j < 8) ? 3'd2 : 3'd3, 3'd0};
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 14; n++) begin
            applyStimulus(1'b1, pts[n][8:6], pts[n][5:3], pts[n][2:0]);
            tick();
            checkCount++;
            if ({count, done} !== {4'(n + 1), (n == 13)})
                $display("[TB] FAIL stall_accept %0d: got c%0d d%0d expected c%0d d%0d", n, count, done, n + 1, (n == 13));
            else passCount++;
            applyStimulus(1'b0, 3'd7, 3'd7, 3'd7);
            tick();
            checkCount++;
            if (count !== 4'(n + 1))
                $display("[TB] FAIL stall_gap %0d: got c%0d expected c%0d", n, count, n + 1);
            else passCount++;
        end
        checkCount++;
        if ({repeat_cnt, xmin, xmax, ymin, ymax, zmin, zmax} !== {4'd2, 3'd0, 3'd7, 3'd1, 3'd3, 3'd0, 3'd1})
            $display("[TB] FAIL repeat_bbox: got rep%0d %0d %0d %0d %0d %0d %0d expected rep2 0 7 1 3 0 1", repeat_cnt, xmin, xmax, ymin, ymax, zmin, zmax);
        else passCount++;
        applyStimulus(1'b1, 3'd7, 3'd7, 3'd7);
        tick();
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
        checkCount++;
        if ({count, done, xmax, ymax, zmax} !== {4'd14, 1'b1, 3'd7, 3'd3, 3'd1})
            $display("[TB] FAIL valid_in_done: got c%0d d%0d max %0d %0d %0d expected c14 d1 max 7 3 1", count, done, xmax, ymax, zmax);
        else passCount++;
        for (int k = 0; k < 4; k++) begin
            issueRead(addrs[k]);
            checkCount++;
            if ({rd_valid, rd_x, rd_y, rd_z} !== {1'b1, expd[k]})
                $display("[TB] FAIL frame2_read addr %0d: got v%0d (%0d,%0d,%0d) expected v1 data %h", addrs[k], rd_valid, rd_x, rd_y, rd_z, expd[k]);
            else passCount++;
        end
    endtask

    // Scenario sequence; each test continues from the state the previous one left.
    initial begin
        reset = 1'b0;
        start = 1'b0;
        rd_en = 1'b0;
        rd_addr = 4'd0;
        applyStimulus(1'b0, 3'd0, 3'd0, 3'd0);
        test_reset();
        test_full_frame();
        test_readout();
        test_back_to_back();
        test_mid_reset();
        test_repeats_stalls();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
